// File: rtl/frame_buf_pkg.sv
// Shared encodings and defaults for the stereo frame buffer write path.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_L = 2'b01,
    ST_GNT_R = 2'b10
  } arb_state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_LEFT  = 2'b01;
  localparam logic [1:0] GNT_RIGHT = 2'b10;

  localparam logic ASSERT   = 1'b1;
  localparam logic DEASSERT = 1'b0;

  // Encoding of the round-robin "last served" pointer.
  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int DEF_BUF_SIZE    = 307200;
  localparam int DEF_BASE_ADDR_L = 2;
  localparam int DEF_BASE_ADDR_R = 307202;

endpackage

// File: rtl/frame_wr_arb_addr_gen.sv
// Per-stream frame address generator: offset within one frame region,
// restart on sof, wrap at the end of the frame and a registered frame_done pulse.
module frame_addr_gen
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int BUF_SIZE   = DEF_BUF_SIZE
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_beat,
  input  logic                  i_sof,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_frame_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(BUF_SIZE - 1);

  logic [ADDR_WIDTH-1:0] r_off;
  logic                  r_frame_done;
  logic [ADDR_WIDTH-1:0] w_off_cur;
  logic                  w_wrap;

  // sof forces the presented beat to offset 0 even before it is accepted,
  // so the address stays stable across a stall.
  assign w_off_cur    = i_sof ? '0 : r_off;
  assign w_wrap       = (w_off_cur == LAST_OFF);
  assign o_addr       = i_base + w_off_cur;
  assign o_frame_done = r_frame_done;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_off        <= '0;
      r_frame_done <= DEASSERT;
    end else begin
      r_frame_done <= (i_beat && w_wrap) ? ASSERT : DEASSERT;
      if (i_beat) begin
        r_off <= w_wrap ? '0 : w_off_cur + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_wr_arb.sv
// Two-requester round-robin write arbiter sharing one memory write port
// between the left and right camera streams, with per-stream frame addressing.
module frame_wr_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 29,
  parameter int BASE_ADDR_L = DEF_BASE_ADDR_L,
  parameter int BASE_ADDR_R = DEF_BASE_ADDR_R,
  parameter int BUF_SIZE    = DEF_BUF_SIZE,
  parameter int BURST_LEN   = 8
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  i_req_l,
  input  logic                  i_req_r,
  input  logic [DATA_WIDTH-1:0] i_data_l,
  input  logic [DATA_WIDTH-1:0] i_data_r,
  input  logic                  i_sof_l,
  input  logic                  i_sof_r,
  output logic                  o_ack_l,
  output logic                  o_ack_r,
  output logic                  o_mem_wr_en,
  input  logic                  i_mem_wr_rdy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_frame_done_l,
  output logic                  o_frame_done_r,
  output logic [1:0]            o_gnt,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a requester holds req/data/sof stable until it sees ack in the
  // same cycle; a beat moves on the clock edge where req, grant and
  // mem_wr_rdy are all high. mem_wr_rdy low is a pure stall.

  localparam int                    CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]      BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE_L    = ADDR_WIDTH'(BASE_ADDR_L);
  localparam logic [ADDR_WIDTH-1:0] BASE_R    = ADDR_WIDTH'(BASE_ADDR_R);

  if (longint'(BASE_ADDR_L) + longint'(BUF_SIZE) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_l
    $error("frame_wr_arb: left frame region exceeds the address space");
  end
  if (longint'(BASE_ADDR_R) + longint'(BUF_SIZE) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_r
    $error("frame_wr_arb: right frame region exceeds the address space");
  end

  arb_state_t        r_state, w_next_state;
  logic              r_last, w_next_last;
  logic [CNT_W-1:0]  r_beat_cnt, w_next_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_req_gnt, w_req_other, w_beat;
  logic              w_ack_l, w_ack_r;
  logic [ADDR_WIDTH-1:0] w_addr_l, w_addr_r;

  always_comb begin
    w_req_gnt   = DEASSERT;
    w_req_other = DEASSERT;
    case (r_state)
      ST_GNT_L: begin w_req_gnt = i_req_l; w_req_other = i_req_r; end
      ST_GNT_R: begin w_req_gnt = i_req_r; w_req_other = i_req_l; end
      default:  ;
    endcase
  end

  assign w_beat    = w_req_gnt && i_mem_wr_rdy && !reset;
  assign w_ack_l   = (r_state == ST_GNT_L) && w_beat;
  assign w_ack_r   = (r_state == ST_GNT_R) && w_beat;
  assign w_cnt_inc = r_beat_cnt + 1'b1;

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    w_next_cnt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_req_l && (!i_req_r || r_last == SIDE_R)) begin
          w_next_state = ST_GNT_L;
        end else if (i_req_r) begin
          w_next_state = ST_GNT_R;
        end
      end
      ST_GNT_L, ST_GNT_R: begin
        if (w_beat) begin
          w_next_last = (r_state == ST_GNT_L) ? SIDE_L : SIDE_R;
          w_next_cnt  = w_cnt_inc;
        end
        // Burst end with nobody else waiting keeps the grant with a fresh count.
        if (!w_req_gnt || (w_beat && w_cnt_inc == BURST_MAX)) begin
          w_next_cnt = '0;
          if (w_req_other) begin
            w_next_state = (r_state == ST_GNT_L) ? ST_GNT_R : ST_GNT_L;
          end else if (!w_req_gnt) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last     <= SIDE_R;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_last     <= w_next_last;
      r_beat_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    o_gnt = GNT_NONE;
    case (r_state)
      ST_GNT_L: o_gnt = GNT_LEFT;
      ST_GNT_R: o_gnt = GNT_RIGHT;
      default:  o_gnt = GNT_NONE;
    endcase
  end

  assign o_dbg_state = r_state;
  assign o_ack_l     = w_ack_l;
  assign o_ack_r     = w_ack_r;
  assign o_mem_wr_en = w_req_gnt && !reset;
  assign o_mem_data  = (r_state == ST_GNT_R) ? i_data_r : i_data_l;
  assign o_mem_addr  = (r_state == ST_GNT_R) ? w_addr_r : w_addr_l;

  frame_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUF_SIZE   (BUF_SIZE)
  ) u_addr_l (
    .wr_clk       (wr_clk),
    .reset        (reset),
    .i_base       (BASE_L),
    .i_beat       (w_ack_l),
    .i_sof        (i_sof_l),
    .o_addr       (w_addr_l),
    .o_frame_done (o_frame_done_l)
  );

  frame_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUF_SIZE   (BUF_SIZE)
  ) u_addr_r (
    .wr_clk       (wr_clk),
    .reset        (reset),
    .i_base       (BASE_R),
    .i_beat       (w_ack_r),
    .i_sof        (i_sof_r),
    .o_addr       (w_addr_r),
    .o_frame_done (o_frame_done_r)
  );

endmodule

// File: tb/tb_frame_wr_arb.sv
// Bench for frame_wr_arb: directed arbitration/addressing scenarios plus random
// traffic, checked by a per-stream scoreboard against a frame-offset model.
module tb_frame_wr_arb;
  import frame_buf_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 29;
  localparam int BL    = 2;
  localparam int BR    = 307202;
  localparam int BUF   = 16;
  localparam int BURST = 8;
  localparam int EW    = 1 + AW + DW;
  localparam int LIM   = 100;

  logic          wr_clk, reset;
  logic          i_req_l, i_req_r, i_sof_l, i_sof_r, i_mem_wr_rdy;
  logic [DW-1:0] i_data_l, i_data_r, o_mem_data;
  logic          o_ack_l, o_ack_r, o_mem_wr_en, o_frame_done_l, o_frame_done_r;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    o_gnt, o_dbg_state;

  frame_wr_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR_L(BL), .BASE_ADDR_R(BR),
    .BUF_SIZE(BUF), .BURST_LEN(BURST)
  ) dut (
    .wr_clk(wr_clk), .reset(reset),
    .i_req_l(i_req_l), .i_req_r(i_req_r), .i_data_l(i_data_l), .i_data_r(i_data_r),
    .i_sof_l(i_sof_l), .i_sof_r(i_sof_r), .o_ack_l(o_ack_l), .o_ack_r(o_ack_r),
    .o_mem_wr_en(o_mem_wr_en), .i_mem_wr_rdy(i_mem_wr_rdy), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_frame_done_l(o_frame_done_l), .o_frame_done_r(o_frame_done_r),
    .o_gnt(o_gnt), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q_l[$];
  logic [EW-1:0] exp_q_r[$];
  logic [0:0]    exp_side_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  off_m[2];
  bit  pend_done[2];
  int  cyc = 0;
  int  rdy_mode = 0;
  bit  win_arm = 0;
  int  win_first = -1;
  int  win_last  = -1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: each stream writes its beats in order into its own
  // region; the offset restarts at sof and wraps after the last word.
  function automatic void model_push(input int side, input logic [DW-1:0] d, input bit sof);
    int            o;
    bit            wrap;
    logic [AW-1:0] a;
    o    = sof ? 0 : off_m[side];
    wrap = (o == BUF - 1);
    a    = AW'((side == 0 ? BL : BR) + o);
    off_m[side] = wrap ? 0 : o + 1;
    if (side == 0) exp_q_l.push_back({wrap, a, d});
    else           exp_q_r.push_back({wrap, a, d});
  endfunction

  // ---------------- monitor ----------------
  task automatic mon_side(input int side);
    logic          ack, done, wrap;
    logic [EW-1:0] e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [0:0]    s;
    int            qsz;
    ack  = (side == 0) ? o_ack_l : o_ack_r;
    done = (side == 0) ? o_frame_done_l : o_frame_done_r;
    qsz  = (side == 0) ? exp_q_l.size() : exp_q_r.size();
    check($sformatf("frame_done_%0d", side), done, pend_done[side]);
    pend_done[side] = 1'b0;
    if (ack) begin
      check("ack_wr_en", o_mem_wr_en, 1);
      check("ack_rdy", i_mem_wr_rdy, 1);
      check($sformatf("ack_gnt_%0d", side), o_gnt, (side == 0) ? GNT_LEFT : GNT_RIGHT);
      if (qsz == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack_%0d: got ack, expected no beat pending", side);
      end else begin
        e = (side == 0) ? exp_q_l.pop_front() : exp_q_r.pop_front();
        {wrap, a, d} = e;
        check($sformatf("addr_%0d", side), o_mem_addr, a);
        check($sformatf("data_%0d", side), o_mem_data, d);
        pend_done[side] = wrap;
      end
      if (exp_side_q.size() > 0) begin
        s = exp_side_q.pop_front();
        check("ack_order", side, s);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge wr_clk);
      cyc++;
      check("single_ack", o_ack_l & o_ack_r, 0);
      mon_side(0);
      mon_side(1);
      if (!win_arm) win_first = -1;
      else if (o_ack_l || o_ack_r) begin
        if (win_first < 0) win_first = cyc;
        win_last = cyc;
      end
    end
  end

  // ---------------- memory ready driver ----------------
  initial begin
    bit pat[4];
    int pidx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pidx = 0;
    i_mem_wr_rdy = 1'b1;
    forever begin
      @(posedge wr_clk);
      #1;
      case (rdy_mode)
        0: begin i_mem_wr_rdy = 1'b1; pidx = 0; end
        1: begin i_mem_wr_rdy = ($urandom_range(0, 3) != 0); pidx = 0; end
        default: begin i_mem_wr_rdy = pat[pidx]; pidx = (pidx + 1) % 4; end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge wr_clk); #1; end
  endtask

  task automatic reset_dut(input int n);
    reset = 1'b1;
    i_req_l = 1'b0; i_req_r = 1'b0; i_sof_l = 1'b0; i_sof_r = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge wr_clk);
      check("rst_wr_en", o_mem_wr_en, 0);
      check("rst_ack", {o_ack_l, o_ack_r}, 0);
      if (i > 0) begin
        check("rst_gnt", o_gnt, GNT_NONE);
        check("rst_frame_done", {o_frame_done_l, o_frame_done_r}, 0);
      end
      @(posedge wr_clk);
      #1;
    end
    reset = 1'b0;
    off_m[0] = 0;
    off_m[1] = 0;
  endtask

  // Sends n beats on one side; returns the wait of the first beat and the
  // total number of cycles spent.
  task automatic send(input int side, input int n, input bit sof_first, input int delay,
                      output int first_wait, output int total);
    logic [DW-1:0] d;
    bit            sof, got, a;
    int            iters;
    first_wait = -1;
    total = 0;
    repeat (delay) begin @(posedge wr_clk); #1; end
    for (int i = 0; i < n; i++) begin
      d   = $urandom;
      sof = sof_first && (i == 0);
      model_push(side, d, sof);
      if (side == 0) begin i_req_l = 1'b1; i_data_l = d; i_sof_l = sof; end
      else           begin i_req_r = 1'b1; i_data_r = d; i_sof_r = sof; end
      got = 1'b0;
      iters = 0;
      for (int c = 0; c < LIM && !got; c++) begin
        @(negedge wr_clk);
        a = (side == 0) ? o_ack_l : o_ack_r;
        iters++;
        if (a) got = 1'b1;
        @(posedge wr_clk);
        #1;
      end
      total += iters;
      if (i == 0) first_wait = iters - 1;
      if (!got) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout_%0d: got no ack, expected ack within %0d cycles", side, LIM);
        if (side == 0) void'(exp_q_l.pop_back());
        else           void'(exp_q_r.pop_back());
      end
    end
    if (side == 0) begin i_req_l = 1'b0; i_sof_l = 1'b0; end
    else           begin i_req_r = 1'b0; i_sof_r = 1'b0; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fw0, tot0, fw1, tot1;
    reset = 1'b1;
    i_req_l = 1'b0; i_req_r = 1'b0; i_sof_l = 1'b0; i_sof_r = 1'b0;
    i_data_l = '0; i_data_r = '0;
    off_m[0] = 0; off_m[1] = 0;
    pend_done[0] = 1'b0; pend_done[1] = 1'b0;

    // Reset state and single-side burst of 3 with sof.
    reset_dut(3);
    @(negedge wr_clk);
    check("post_rst_gnt", o_gnt, GNT_NONE);
    check("post_rst_state", o_dbg_state, 2'b00);
    @(posedge wr_clk); #1;
    send(0, 3, 1'b1, 0, fw0, tot0);
    check("t1_first_ack_latency", fw0, 1);
    check("t1_burst_cycles", tot0, 4);
    check("t1_gnt_hold", o_gnt, GNT_LEFT);
    @(posedge wr_clk); #1;
    check("t1_gnt_idle", o_gnt, GNT_NONE);

    // Both streams contending: L wins the first tie, bursts of 8, no dead cycles.
    // L sends a full 16-word frame, so its last write wraps with frame_done.
    reset_dut(2);
    for (int i = 0; i < 24; i++) exp_side_q.push_back((i >= 8 && i < 16) ? 1'b1 : 1'b0);
    win_arm = 1'b1;
    fork
      send(0, 16, 1'b1, 0, fw0, tot0);
      send(1, 8, 1'b1, 0, fw1, tot1);
    join
    win_arm = 1'b0;
    check("t2_ack_window", win_last - win_first, 23);
    check("t2_order_consumed", exp_side_q.size(), 0);
    idle(3);

    // Stalls: rdy 1,0,0,1 pattern; L must make 8 real beats before R gets in.
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) exp_side_q.push_back((i == 8) ? 1'b1 : 1'b0);
    fork
      send(0, 9, 1'b0, 0, fw0, tot0);
      send(1, 1, 1'b0, 2, fw1, tot1);
    join
    rdy_mode = 0;
    check("t4_order_consumed", exp_side_q.size(), 0);
    idle(3);

    // sof on R mid-frame restarts at the region base.
    reset_dut(2);
    send(1, 5, 1'b1, 0, fw1, tot1);
    idle(1);
    send(1, 2, 1'b1, 0, fw1, tot1);
    idle(2);

    // Reset during an R burst at offset 4: the in-flight beat is dropped.
    reset_dut(2);
    send(1, 4, 1'b1, 0, fw1, tot1);
    i_req_r = 1'b1; i_data_r = $urandom; i_sof_r = 1'b0;
    reset = 1'b1;
    @(negedge wr_clk);
    check("t6_rst_ack", o_ack_r, 0);
    check("t6_rst_wr_en", o_mem_wr_en, 0);
    @(posedge wr_clk); #1;
    reset = 1'b0;
    i_req_r = 1'b0;
    off_m[0] = 0; off_m[1] = 0;
    @(negedge wr_clk);
    check("t6_gnt_after_rst", o_gnt, GNT_NONE);
    @(posedge wr_clk); #1;
    send(1, 1, 1'b0, 0, fw1, tot1);
    idle(2);

    // Random traffic with random ready.
    rdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      fork
        send(0, $urandom_range(1, 12), $urandom_range(0, 3) == 0, $urandom_range(0, 3), fw0, tot0);
        send(1, $urandom_range(1, 12), $urandom_range(0, 3) == 0, $urandom_range(0, 3), fw1, tot1);
      join
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    idle(4);
    check("end_q_l_empty", exp_q_l.size(), 0);
    check("end_q_r_empty", exp_q_r.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
